// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared by the producers, the arbiter and the FIFO write port.
// master is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DataWidth = 16,
  parameter int NumReq    = 4
);
  localparam int IdWidth = $clog2(NumReq);

  logic [NumReq*DataWidth-1:0] req_data_i;
  logic [NumReq-1:0]           req_val_i;
  logic [NumReq-1:0]           req_last_i;
  logic [NumReq-1:0]           req_rdy_o;
  logic [IdWidth+DataWidth-1:0] fifo_din_o;
  logic                        fifo_din_val_o;
  logic                        fifo_din_rdy_i;
  logic [NumReq-1:0]           grant_o;
  logic                        busy_o;

  modport master (
    input  req_data_i, req_val_i, req_last_i, fifo_din_rdy_i,
    output req_rdy_o, fifo_din_o, fifo_din_val_o, grant_o, busy_o
  );

  modport slave (
    output req_data_i, req_val_i, req_last_i, fifo_din_rdy_i,
    input  req_rdy_o, fifo_din_o, fifo_din_val_o, grant_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NumReq producers.
// A grant is held until req_last or MaxBurst beats; each beat carries its source id.
module fifo_wr_arbiter #(
  parameter int DataWidth = 16,
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 8
) (
  input logic               clk_i,
  input logic               arst_ni,
  fifo_wr_arbiter_if.master bus
);
  localparam int IdWidth  = $clog2(NumReq);
  localparam int CntWidth = $clog2(MaxBurst + 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e                state_q;
  logic [NumReq-1:0]     grant_q;
  logic [IdWidth-1:0]    gidx_q;
  logic [IdWidth-1:0]    rr_ptr_q;
  logic [CntWidth-1:0]   beat_cnt_q;

  logic                  win_found;
  logic [IdWidth-1:0]    win_idx;
  logic [IdWidth-1:0]    cand;
  logic [DataWidth-1:0]  sel_data;
  logic                  sel_val;
  logic                  sel_last;
  logic                  locked;
  logic                  beat;
  logic                  release_burst;

  function automatic logic [IdWidth-1:0] wrap_idx(input logic [IdWidth-1:0] base,
                                                  input int unsigned ofs);
    int unsigned s;
    s = (32'(base) + ofs) % 32'(NumReq);
    return s[IdWidth-1:0];
  endfunction

  // Search starts just after the last served requester, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = wrap_idx(rr_ptr_q, 32'(i));
      if (!win_found && bus.req_val_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_val  = 1'b0;
    sel_last = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (gidx_q == IdWidth'(k)) begin
        sel_data = bus.req_data_i[k*DataWidth +: DataWidth];
        sel_val  = bus.req_val_i[k];
        sel_last = bus.req_last_i[k];
      end
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign beat          = locked && sel_val && bus.fifo_din_rdy_i;
  assign release_burst = sel_last || (beat_cnt_q == CntWidth'(MaxBurst - 1));

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= IdWidth'(NumReq - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q    <= ST_LOCKED;
            gidx_q     <= win_idx;
            grant_q    <= NumReq'(1) << win_idx;
            beat_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (beat) begin
            if (release_burst) begin
              state_q    <= ST_IDLE;
              grant_q    <= '0;
              beat_cnt_q <= '0;
              rr_ptr_q   <= gidx_q;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntWidth'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // grant_q is zero while idle, so ready needs no extra state qualification.
  assign bus.grant_o        = grant_q;
  assign bus.busy_o         = locked;
  assign bus.req_rdy_o      = grant_q & {NumReq{bus.fifo_din_rdy_i}};
  assign bus.fifo_din_val_o = locked && sel_val;
  assign bus.fifo_din_o     = locked ? {gidx_q, sel_data} : '0;
endmodule
